// File: rtl/demux_scan_pkg.sv
// Shared definitions for the demux_scan selector reader: FSM encoding and settle-counter width.
package demux_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/scan_settle_timer.sv
// Loadable down-counter: load wins over decrement, stops at zero, o_tc flags a count of one.
// Latency: o_tc follows the registered count; no flow control of its own.
module scan_settle_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  output logic          o_tc
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc = (r_cnt == CW'(1));

endmodule

// File: rtl/demux_scan.sv
// Steps an external 8:1-style selector through every line, SETTLE+1 cycles per line, into q; WIDTH*(SETTLE+1) cycles start-to-valid.
// Word held with valid until ack; starts outside IDLE are dropped. DEMUX_SCAN_CHECK_EN adds w/err complementary-output check.
module demux_scan
  import demux_scan_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SELW   = 3,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             i_start,
  output logic [SELW-1:0]  o_sel,
  output logic             o_ne,
  input  logic             i_y,
  output logic             o_busy,
  output logic             o_valid,
  input  logic             i_ack,
  output logic [WIDTH-1:0] o_q
`ifdef DEMUX_SCAN_CHECK_EN
  , input  logic           i_w,
  output logic             o_err
`endif
);

  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE);
  localparam logic [SELW-1:0]  SEL_LAST   = SELW'(WIDTH - 1);
  localparam logic             NO_SETTLE  = (SETTLE == 0);

  state_t            r_state, w_nxt;
  logic [SELW-1:0]   r_sel;
  logic [WIDTH-1:0]  r_q;
  logic              r_ne, r_busy, r_valid;
  logic              w_go, w_sample, w_load, w_dec, w_ack, w_tc, w_last;

  scan_settle_timer #(.CW(CNT_W)) u_timer (
    .clk        (clk),
    .nreset     (nreset),
    .i_load     (w_load),
    .i_load_val (SETTLE_LD),
    .i_dec      (w_dec),
    .o_tc       (w_tc)
  );

  assign w_last = (r_sel == SEL_LAST);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_state <= ST_IDLE;
    else         r_state <= w_nxt;
  end

  always_comb begin
    w_nxt    = r_state;
    w_go     = 1'b0;
    w_sample = 1'b0;
    w_load   = 1'b0;
    w_dec    = 1'b0;
    w_ack    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_go   = 1'b1;
          w_load = 1'b1;
          w_nxt  = NO_SETTLE ? ST_SAMPLE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        w_dec = 1'b1;
        if (w_tc) w_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        w_sample = 1'b1;
        if (w_last) begin
          w_nxt = ST_DONE;
        end else begin
          w_load = 1'b1;
          w_nxt  = NO_SETTLE ? ST_SAMPLE : ST_SETTLE;
        end
      end
      default: begin
        if (i_ack) begin
          w_ack = 1'b1;
          w_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // sel holds its last line after a scan; only a new start returns it to 0
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_sel   <= '0;
      r_ne    <= 1'b1;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_q     <= '0;
    end else begin
      r_busy <= (w_nxt == ST_SETTLE) || (w_nxt == ST_SAMPLE);
      if (w_go) begin
        r_sel <= '0;
        r_ne  <= 1'b0;
        r_q   <= '0;
      end
      if (w_sample) begin
        r_q[r_sel] <= i_y;
        if (w_last) begin
          r_ne    <= 1'b1;
          r_valid <= 1'b1;
        end else begin
          r_sel <= r_sel + 1'b1;
        end
      end
      if (w_ack) r_valid <= 1'b0;
    end
  end

`ifdef DEMUX_SCAN_CHECK_EN
  logic r_err;

  // a healthy mux drives w as the complement of y; equality marks a faulty line
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_err <= 1'b0;
    end else if (w_go || w_ack) begin
      r_err <= 1'b0;
    end else if (w_sample && (i_w == i_y)) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`endif

  assign o_sel   = r_sel;
  assign o_ne    = r_ne;
  assign o_busy  = r_busy;
  assign o_valid = r_valid;
  assign o_q     = r_q;

endmodule
